nios2_sw_debounce: RTL and testbench

Conditions the raw 10-bit slide-switch bus before it reaches the Nios II input PIO's in_port. Each bit passes through a 2-flop synchronizer, then a per-bit tick-based debouncer. The block outputs a clean, glitch-free level bus and a one-cycle change strobe. It sits directly upstream of the PIO and uses the same single system clock domain.

---
 rtl/nios2_sw_debounce.sv | 157 +++++++++++++++
 tb/tb_nios2_sw_debounce.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_sw_debounce.sv
// nios2_sw_debounce
// Conditions the raw slide-switch bus ahead of the Nios II input PIO.
// Each bit goes through a 2-flop synchronizer, then a tick-based debouncer
// that accepts a new level only after STABLE_CNT consecutive mismatching
// sample ticks. Outputs are a clean level bus, a one-cycle change strobe
// and the sample tick itself.
//
// Optional feature macro: NIOS2_SW_DEBOUNCE_EDGE_CAPTURE_EN
//   When defined, sticky rising-edge flags (rise_cap) with a per-bit clear
//   mask (cap_clr) are built. When undefined, rise_cap is tied to 0 and
//   cap_clr is ignored. The port list is the same in both builds.
module nios2_sw_debounce #(
  parameter int WIDTH      = 10,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic             sw_chg,
  output logic             tick,
  input  logic [WIDTH-1:0] cap_clr,
  output logic [WIDTH-1:0] rise_cap
);

  // Prescaler width covers 0..TICK_DIV-1; counter width covers 0..STABLE_CNT.
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

  // ---------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Two-flop synchronizer bringing the asynchronous pins into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // ---------------------------------------------------------------------
  // Sample-tick prescaler
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic          tick_r;

  // Next prescaler count: wraps to zero after the last count.
  always_comb begin
    presc_nxt_s = presc_r;
    if (presc_r == PRESC_LAST) begin
      presc_nxt_s = {PW{1'b0}};
    end else begin
      presc_nxt_s = presc_r + PW'(1);
    end
  end

  // Prescaler register; tick is registered so it is high exactly while the
  // count sits at its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_nxt_s;
      tick_r  <= (presc_nxt_s == PRESC_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Per-bit debounce counters
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0][CW-1:0] cnt_r;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]         db_r;
  logic [WIDTH-1:0]         db_nxt_s;
  logic                     chg_r;

  // Qualification rules per bit: a match clears the count at once, a
  // mismatch advances it only on ticks, and the last qualifying tick
  // accepts the synchronized level. The count therefore never wraps.
  always_comb begin
    cnt_nxt_s = cnt_r;
    db_nxt_s  = db_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == db_r[i]) begin
        cnt_nxt_s[i] = {CW{1'b0}};
      end else if (tick_r) begin
        if (cnt_r[i] == CNT_LAST) begin
          db_nxt_s[i]  = sync2_r[i];
          cnt_nxt_s[i] = {CW{1'b0}};
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CW'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Counter, debounced level and change-strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {(WIDTH*CW){1'b0}};
      db_r  <= {WIDTH{1'b0}};
      chg_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      db_r  <= db_nxt_s;
      chg_r <= |(db_nxt_s ^ db_r);
    end
  end

  // ---------------------------------------------------------------------
  // Optional rising-edge capture
  // ---------------------------------------------------------------------
`ifdef NIOS2_SW_DEBOUNCE_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] rise_nxt_s;

  // Clear first, then set, so a rise in the same cycle as a clear wins.
  always_comb begin
    rise_nxt_s = (rise_r & ~cap_clr) | (db_nxt_s & ~db_r);
  end

  // Sticky rising-edge flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_r <= {WIDTH{1'b0}};
    end else begin
      rise_r <= rise_nxt_s;
    end
  end

  assign rise_cap = rise_r;
`else
  // Feature absent: the clear mask is intentionally left unconnected.
  logic unused_cap_clr;
  assign unused_cap_clr = ^cap_clr;
  assign rise_cap       = {WIDTH{1'b0}};
`endif

  assign sw_db  = db_r;
  assign sw_chg = chg_r;
  assign tick   = tick_r;

endmodule

// File: tb/tb_nios2_sw_debounce.sv
// Testbench for nios2_sw_debounce (TICK_DIV=4, STABLE_CNT=3).
// A reference model predicts each debounced change; predictions go into a
// scoreboard queue that a negedge monitor drains whenever sw_chg pulses.
module tb_nios2_sw_debounce;

  localparam int W = 10;
  localparam int T = 4;
  localparam int S = 3;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] cap_clr;
  logic [W-1:0] sw_db;
  logic         sw_chg;
  logic         tick;
  logic [W-1:0] rise_cap;

  nios2_sw_debounce #(.WIDTH(W), .TICK_DIV(T), .STABLE_CNT(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_db    (sw_db),
    .sw_chg   (sw_chg),
    .tick     (tick),
    .cap_clr  (cap_clr),
    .rise_cap (rise_cap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int chg_seen = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Model view: two-cycle delay line of raw input, a tick every T-th cycle
  // since reset release, and per bit the number of ticks seen while the
  // delayed input has continuously disagreed with the accepted level.
  typedef struct { int at; logic [W-1:0] db; } exp_t;
  exp_t sb_q[$];

  logic [W-1:0] m_s1, m_s2, m_db, m_rise;
  logic         m_tick;
  int           m_seen[W];
  int           m_edges;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_tick = 1'b0; m_edges = 0;
    for (int i = 0; i < W; i++) m_seen[i] = 0;
    sb_q.delete();
  endtask

  function automatic logic [W-1:0] model_next_db();
    logic [W-1:0] nd;
    nd = m_db;
    for (int i = 0; i < W; i++)
      if (m_s2[i] != m_db[i] && m_tick && (m_seen[i] + 1 == S)) nd[i] = m_s2[i];
    return nd;
  endfunction

  // Advance the model across one rising edge using the inputs seen at it.
  task automatic model_step();
    logic [W-1:0] nd;
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      nd = model_next_db();
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_db[i] || nd[i] != m_db[i]) m_seen[i] = 0;
        else if (m_tick) m_seen[i] = m_seen[i] + 1;
      end
`ifdef NIOS2_SW_DEBOUNCE_EDGE_CAPTURE_EN
      m_rise = (m_rise & ~cap_clr) | (nd & ~m_db);
`endif
      if (nd != m_db) sb_q.push_back('{cyc, nd});
      m_db = nd;
      m_s2 = m_s1;
      m_s1 = sw_raw;
      m_edges++;
      m_tick = ((m_edges % T) == T - 1);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("sw_db", 32'(sw_db), 32'(m_db));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("rise_cap", 32'(rise_cap), 32'(m_rise));
      if (sw_chg) begin
        chg_seen++;
        if (sb_q.size() == 0) begin
          chk("sw_chg_spurious", 32'(sw_chg), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("chg_cycle", 32'(cyc), 32'(e.at));
          chk("chg_db", 32'(sw_db), 32'(e.db));
        end
      end else if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sw_chg_missing", 32'(sw_chg), 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input logic [W-1:0] raw, input logic [W-1:0] clr);
    sw_raw  = raw;
    cap_clr = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_db(input logic [W-1:0] raw, input int b, input logic lvl,
                         input int lim, output int lat);
    lat = -1;
    for (int n = 1; n <= lim; n++) begin
      cycle(raw, 10'h000);
      if (sw_db[b] === lvl) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic settle(input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) cycle(raw, 10'h000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, ft, base, ticks;
    logic [W-1:0] raw, nd, clr;

    // 1) Reset held with all switches high, then release.
    reset = 1'b1; sw_raw = 10'h3FF; cap_clr = 10'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw_db", 32'(sw_db), 32'd0);
    chk("rst_sw_chg", 32'(sw_chg), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rise_cap", 32'(rise_cap), 32'd0);
    model_clear();
    reset = 1'b0;
    base = chg_seen; ft = -1; lat = -1;
    for (int n = 1; n <= 30; n++) begin
      cycle(10'h3FF, 10'h000);
      if (tick && ft < 0) ft = n;
      if (sw_db == 10'h3FF && lat < 0) lat = n;
      if (lat > 0 && n >= lat + 2) break;
    end
    chk("first_tick_edge", 32'(ft), 32'd3);
    chk("rst_qual_lat", 32'(lat), 32'd12);
    chk("rst_qual_db", 32'(sw_db), 32'h3FF);
    chk("rst_qual_chg_pulses", 32'(chg_seen - base), 32'd1);

    // 2) Clean press on bit 0 from an all-zero level.
    settle(10'h000, 20);
    base = chg_seen;
    wait_db(10'h001, 0, 1'b1, 30, lat);
    chk("press_lat_in_window", 32'(lat >= 11 && lat <= 14), 32'd1);
    chk("press_other_bits", 32'(sw_db[9:1]), 32'd0);
    settle(10'h001, 3);
    chk("press_chg_pulses", 32'(chg_seen - base), 32'd1);

    // 3) Bounce on bit 3: 1,0,1,0 every 2 cycles, then held high.
    for (int k = 0; k < 4; k++) begin
      raw = (k % 2 == 0) ? 10'h009 : 10'h001;
      settle(raw, 2);
    end
    chk("bounce_hold_low", 32'(sw_db[3]), 32'd0);
    wait_db(10'h009, 3, 1'b1, 30, lat);
    chk("bounce_lat_in_window", 32'(lat >= 11 && lat <= 14), 32'd1);

    // 4) Short glitch on bit 5 (3 cycles).
    settle(10'h009, 4);
    base = chg_seen;
    settle(10'h029, 3);
    settle(10'h009, 20);
    chk("glitch_db5", 32'(sw_db[5]), 32'd0);
    chk("glitch_chg_pulses", 32'(chg_seen - base), 32'd0);

    // 5) Async reset after two qualifying ticks on bit 7.
    ticks = 0;
    for (int n = 1; n <= 30 && ticks < 2; n++) begin
      cycle(10'h089, 10'h000);
      if (n >= 2 && tick) ticks++;
    end
    cycle(10'h089, 10'h000);
    chk("mid_db7_pre", 32'(sw_db[7]), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sw_db", 32'(sw_db), 32'd0);
    chk("mid_rst_sw_chg", 32'(sw_chg), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_rise_cap", 32'(rise_cap), 32'd0);
    chk("mid_rst_sb_empty", 32'(sb_q.size()), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_db(10'h089, 7, 1'b1, 30, lat);
    chk("mid_requal_lat", 32'(lat), 32'd12);

    // 6) Randomized switch activity with random clear masks.
    raw = 10'h089;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
      clr = '0;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 3) == 0) clr[i] = 1'b1;
      cycle(raw, clr);
    end
    settle(raw, 20);

`ifdef NIOS2_SW_DEBOUNCE_EDGE_CAPTURE_EN
    // 7) Edge capture: set, no falling capture, set-wins, lone clear.
    settle(10'h000, 20);
    cycle(10'h000, 10'h3FF);
    chk("cap_cleared", 32'(rise_cap), 32'd0);
    wait_db(10'h004, 2, 1'b1, 30, lat);
    chk("cap_first_rise", 32'(rise_cap), 32'h004);
    wait_db(10'h000, 2, 1'b0, 30, lat);
    chk("cap_no_fall", 32'(rise_cap), 32'h004);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      nd  = model_next_db();
      clr = (nd[2] && !m_db[2]) ? 10'h004 : 10'h000;
      cycle(10'h004, clr);
      if (clr[2]) begin
        lat = n;
        break;
      end
    end
    chk("cap_second_rise_seen", 32'(lat > 0), 32'd1);
    chk("cap_set_wins", 32'(rise_cap), 32'h004);
    cycle(10'h004, 10'h004);
    chk("cap_lone_clear", 32'(rise_cap), 32'd0);
    settle(10'h004, 3);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
